// File: rtl/seg7_scan_mux_if.sv
// rtl/seg7_scan_mux_if.sv - digit inputs and display outputs of the 7-segment scan multiplexer
interface seg7_scan_mux_if;
  logic       en;
  logic [3:0] d_disp0;
  logic [3:0] d_disp1;
  logic [3:0] d_disp2;
  logic [3:0] d_disp3;
  logic [3:0] dp_in;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  modport master (
    output en, d_disp0, d_disp1, d_disp2, d_disp3, dp_in,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  en, d_disp0, d_disp1, d_disp2, d_disp3, dp_in,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - 4-digit common-anode scan mux with per-frame snapshot and slot blanking
module seg7_scan_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 2,
  parameter bit LZ_BLANK    = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  seg7_scan_mux_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    snap [4];
  logic [3:0]    snap_dp;
  logic          tick;
  logic          frame_tick;
  logic          slot_blank;
  logic          off;
  logic [3:0]    lz_mask;
  logic [6:0]    glyph;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign tick       = bus.en && (cnt == CW'(REFRESH_DIV - 1));
  assign frame_tick = tick && (idx == 2'd3);

  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign slot_blank = 1'b0;
    end else begin : g_blank
      assign slot_blank = (32'(cnt) < 32'(BLANK_CYC));
    end
  endgenerate

  // Leading-zero suppression chains downward from the leftmost digit; digit 0 always shows
  always_comb begin
    lz_mask = 4'b0000;
    if (LZ_BLANK) begin
      lz_mask[3] = (snap[3] == 4'd0);
      lz_mask[2] = lz_mask[3] && (snap[2] == 4'd0);
      lz_mask[1] = lz_mask[2] && (snap[1] == 4'd0);
    end
    off   = !bus.en || slot_blank || lz_mask[idx];
    glyph = hex7(snap[idx]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      idx            <= 2'd0;
      for (int i = 0; i < 4; i++) snap[i] <= 4'd0;
      snap_dp        <= 4'd0;
      bus.an         <= 4'hF;
      bus.seg        <= 7'h7F;
      bus.dp         <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      if (bus.en) begin
        cnt <= tick ? '0 : cnt + CW'(1);
      end
      if (tick) begin
        idx <= idx + 2'd1;
      end
      // Whole-frame capture keeps a multi-digit value from tearing across the scan
      if (frame_tick) begin
        snap[0] <= bus.d_disp0;
        snap[1] <= bus.d_disp1;
        snap[2] <= bus.d_disp2;
        snap[3] <= bus.d_disp3;
        snap_dp <= bus.dp_in;
      end
      bus.frame_done <= frame_tick;
      if (off) begin
        bus.an  <= 4'hF;
        bus.seg <= 7'h7F;
        bus.dp  <= 1'b1;
      end else begin
        bus.an  <= ~(4'b0001 << idx);
        bus.seg <= ~glyph;
        bus.dp  <= ~snap_dp[idx];
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - randomized scoreboard bench for seg7_scan_mux (plain and leading-zero variants)
module tb_seg7_scan_mux;
  localparam int DIV   = 4;
  localparam int BLANK = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  seg7_scan_mux_if bus();
  seg7_scan_mux_if bus_lz();

  seg7_scan_mux #(.REFRESH_DIV(DIV), .BLANK_CYC(BLANK), .LZ_BLANK(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  seg7_scan_mux #(.REFRESH_DIV(DIV), .BLANK_CYC(BLANK), .LZ_BLANK(1'b1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .bus(bus_lz.slave)
  );

  always #5 clk = ~clk;

  logic       en;
  logic [3:0] d [4];
  logic [3:0] dpi;

  assign bus.en         = en;
  assign bus.d_disp0    = d[0];
  assign bus.d_disp1    = d[1];
  assign bus.d_disp2    = d[2];
  assign bus.d_disp3    = d[3];
  assign bus.dp_in      = dpi;
  assign bus_lz.en      = en;
  assign bus_lz.d_disp0 = d[0];
  assign bus_lz.d_disp1 = d[1];
  assign bus_lz.d_disp2 = d[2];
  assign bus_lz.d_disp3 = d[3];
  assign bus_lz.dp_in   = dpi;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: display state derived from the count of enabled cycles since reset
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int         ecyc;
  logic [3:0] sd [4];
  logic [3:0] sdp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ecyc = 0;
    for (int i = 0; i < 4; i++) sd[i] = 4'd0;
    sdp = 4'd0;
  endtask

  task automatic expect_out(input bit lz, output logic [3:0] ea, output logic [6:0] es, output logic ed);
    int slot;
    int pos;
    logic [3:0] m;
    slot = (ecyc / DIV) % 4;
    pos  = ecyc % DIV;
    m    = 4'b0000;
    if (lz) begin
      m[3] = (sd[3] == 0);
      m[2] = (sd[3] == 0) && (sd[2] == 0);
      m[1] = (sd[3] == 0) && (sd[2] == 0) && (sd[1] == 0);
    end
    if (!en || pos < BLANK || m[slot]) begin
      ea = 4'hF; es = 7'h7F; ed = 1'b1;
    end else begin
      ea = ~(4'b0001 << slot);
      es = ~hex_tab[sd[slot]];
      ed = ~sdp[slot];
    end
  endtask

  task automatic step();
    logic [3:0] ea, ea_lz;
    logic [6:0] es, es_lz;
    logic       ed, ed_lz, efd;
    expect_out(1'b0, ea, es, ed);
    expect_out(1'b1, ea_lz, es_lz, ed_lz);
    efd = en && ((ecyc % (4 * DIV)) == (4 * DIV - 1));
    @(posedge clk);
    #1;
    check("an",        32'(bus.an),            32'(ea));
    check("seg",       32'(bus.seg),           32'(es));
    check("dp",        32'(bus.dp),            32'(ed));
    check("frame",     32'(bus.frame_done),    32'(efd));
    check("lz_an",     32'(bus_lz.an),         32'(ea_lz));
    check("lz_seg",    32'(bus_lz.seg),        32'(es_lz));
    check("lz_dp",     32'(bus_lz.dp),         32'(ed_lz));
    check("lz_frame",  32'(bus_lz.frame_done), 32'(efd));
    if (en) begin
      if (efd) begin
        for (int i = 0; i < 4; i++) sd[i] = d[i];
        sdp = dpi;
      end
      ecyc++;
    end
  endtask

  task automatic run_to_slot2();
    int guard;
    guard = 0;
    while (!(((ecyc / DIV) % 4 == 2) && (ecyc % DIV == 2)) && guard < 40) begin
      step();
      guard++;
    end
    check("reach_slot2", 32'(guard < 40), 32'd1);
  endtask

  initial begin
    en  = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = 4'd0;
    dpi = 4'd0;
    model_reset();

    // Asynchronous reset, sampled before the first clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst_an",    32'(bus.an),         32'hF);
    check("rst_seg",   32'(bus.seg),        32'h7F);
    check("rst_dp",    32'(bus.dp),         32'd1);
    check("rst_frame", 32'(bus.frame_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Digits 1,2,3,4 (d3..d0): first frame zeros, then captured values
    d[0] = 4'd4; d[1] = 4'd3; d[2] = 4'd2; d[3] = 4'd1;
    en = 1'b1;
    repeat (40) step();

    // Mid-frame change of digit 0 waits for the next capture
    repeat (6) step();
    d[0] = 4'd9;
    repeat (30) step();

    // Freeze during the idx=2 slot, then resume
    run_to_slot2();
    en = 1'b0;
    repeat (10) step();
    en = 1'b1;
    repeat (12) step();

    // Leading zeros: d3..d0 = 0,0,5,0
    d[0] = 4'd0; d[1] = 4'd5; d[2] = 4'd0; d[3] = 4'd0;
    repeat (48) step();

    // Reset asserted mid-slot at idx=2 with all decimal points lit
    dpi = 4'hF;
    repeat (32) step();
    run_to_slot2();
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_an",    32'(bus.an),    32'hF);
    check("mid_rst_dp",    32'(bus.dp),    32'd1);
    check("mid_rst_lz_an", 32'(bus_lz.an), 32'hF);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) step();

    // Randomized traffic with occasional enable drops
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 7) == 0) d[$urandom_range(0, 3)] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) dpi = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) begin
        for (int i = 0; i < 4; i++) d[i] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      if (en) begin
        if ($urandom_range(0, 19) == 0) en = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        en = 1'b1;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
